life_sequencer: RTL
===================

Name: life_sequencer

Overview:
Owns the Game of Life cell grid and sequences generation updates for the VGA display block. The next generation is computed row-serially into a shadow buffer, starting on a vsync rising edge. It is committed atomically while still inside vertical blanking, so the display never scans a half-updated grid. The block also provides seed loading, clear, free-run and single-step control.

Parameters:
ROWS, 15, grid rows; must equal display lines / cell size.
COLS, 20, grid columns; must equal display pixels / cell size.
FRAME_DIV, 30, vsync edges per generation in run mode; must be ≥1.
GEN_W, 16, width of the generation counter.

Ports:
clk  in  1  system clock, same clock as the VGA block.
rst_n  in  1  asynchronous active-low reset.
vsync  in  1  vsync from the VGA block; internally 2-flop synchronised.
run  in  1  level; 1 = free-run, advancing one generation every FRAME_DIV frames.
step  in  1  one-cycle pulse; requests exactly one generation.
clear  in  1  one-cycle pulse; zeroes the grid and gen_count.
load_valid  in  1  seed write strobe.
load_row  in  $clog2(ROWS)  row index for the seed write.
load_data  in  COLS  row contents; bit c = column c.
load_ready  out  1  1 only in IDLE.
busy  out  1  1 in COMPUTE or COMMIT.
gen_count  out  GEN_W  number of committed generations.
grid  out  [ROWS-1:0][COLS-1:0]  current grid, indexed grid[row][col]; connects to the VGA grid input.

Behaviour:
- Reset (async, rst_n=0): grid=0, shadow=0, gen_count=0, state=IDLE, frame_cnt=0, step_pending=0, row_idx=0. Outputs: load_ready=1, busy=0.
- vsync path: vsync → sync0 → sync1 → sync1_d. vs_rise = sync1 & ~sync1_d. Edge-detect latency is 2 clocks after vsync is sampled high.
- step_pending: set on a step pulse in any state. Cleared when a trigger consumes it. A step arriving in the same cycle as the consuming trigger stays pending.
- frame_cnt:
  - Increments on each vs_rise while run=1 and state=IDLE.
  - Resets to 0 on trigger, or whenever run=0.
- Trigger, evaluated only in IDLE on vs_rise:
  - trigger = step_pending | (run & frame_cnt==FRAME_DIV-1).
  - If both causes hold, only one generation is computed and step_pending is cleared.
- FSM:
  - IDLE: on trigger → COMPUTE, row_idx=0. Otherwise stay in IDLE.
  - COMPUTE: each cycle, shadow[row_idx] = next-state of row row_idx, computed from the committed grid rows row_idx-1, row_idx and row_idx+1. row_idx increments. After row ROWS-1 → COMMIT. Takes exactly ROWS cycles.
  - COMMIT: grid<=shadow; gen_count<=gen_count+1, wrapping at 2^GEN_W. → IDLE. Takes 1 cycle.
- Timing: if vs_rise is seen in cycle E, COMPUTE occupies E+1..E+ROWS, COMMIT is at E+ROWS+1, and the new grid is visible at E+ROWS+2. This is far inside vertical blanking.
- Cell rule:
  - n = number of live cells among the 8 neighbours (4-bit sum).
  - next = (n==3) | (cur & n==2).
  - Neighbours outside the grid are handled per Optional Feature.
- The committed grid is never written during COMPUTE. Each generation is a pure function of the previous grid.
- Load: when load_valid & IDLE, grid[load_row]<=load_data in the next cycle.
  - Ignored if not in IDLE, or if load_row≥ROWS.
  - No effect on gen_count.
- Clear:
  - In IDLE: grid=0 and gen_count=0; step_pending and frame_cnt are untouched.
  - Outside IDLE: ignored.
  - clear and load in the same cycle: clear wins.
- Simultaneous load/clear and trigger in IDLE: load or clear is applied first, and the trigger is deferred to the next vs_rise. step_pending is kept.
- Reset mid-COMPUTE: immediate return to the reset state. The grid is cleared and no partial commit occurs.

Optional Feature:
- Macro LIFE_WRAP_EN.
- Defined: toroidal grid. Row -1 maps to ROWS-1, row ROWS maps to 0, and columns wrap the same way.
- Undefined: all cells outside the grid count as dead.

Test Plan:
- Reset with grid preloaded to nonzero → grid=0, gen_count=0, load_ready=1, busy=0 immediately on rst_n low.
- Blinker: load row7 = bits 9,10,11; step; one vsync → after ROWS+2 clocks, rows 6,7,8 have bit 10 only, gen_count=1. A second step restores the original pattern, gen_count=2.
- Run with FRAME_DIV=3 and a blinker: 9 vsync edges → exactly 3 commits. busy is high for 16 clocks after each 3rd edge. Grid is stable between commits.
- Glider at top-left corner, LIFE_WRAP_EN defined, 4 steps → glider shifted +1 row/+1 col with its cells wrapped to row ROWS-1/col COLS-1 as needed. Without the macro, the same stimulus gives an edge-clipped pattern matching the dead-boundary reference model.
- load_valid and clear asserted during COMPUTE → both ignored, and the committed grid equals the model's next generation. step and run together on one vs_rise → a single generation.
- rst_n low at COMPUTE row 5 → grid=0, state IDLE. A later vsync with run=0 and no step → no commit.

Source files
------------

// File: rtl/life_sequencer.sv
// Game of Life grid owner: computes each generation row-serially into a shadow buffer
// after a vsync rising edge and commits it atomically. Define LIFE_WRAP_EN for a toroidal grid.
module life_sequencer #(
  parameter int ROWS      = 15,
  parameter int COLS      = 20,
  parameter int FRAME_DIV = 30,
  parameter int GEN_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         vsync,
  input  logic                         run,
  input  logic                         step,
  input  logic                         clear,
  input  logic                         load_valid,
  input  logic [$clog2(ROWS)-1:0]      load_row,
  input  logic [COLS-1:0]              load_data,
  output logic                         load_ready,
  output logic                         busy,
  output logic [GEN_W-1:0]             gen_count,
  output logic [ROWS-1:0][COLS-1:0]    grid
);

  localparam int RW = $clog2(ROWS);
  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

  state_t                      state_q, state_d;
  logic [ROWS-1:0][COLS-1:0]   grid_q, grid_d;
  logic [ROWS-1:0][COLS-1:0]   shadow_q, shadow_d;
  logic [GEN_W-1:0]            gen_count_q, gen_count_d;
  logic [RW-1:0]               row_idx_q, row_idx_d;
  logic [FW-1:0]               frame_cnt_q, frame_cnt_d;
  logic                        step_pending_q, step_pending_d;
  logic                        sync0_q, sync1_q, sync1_d_q;

  logic                        vs_rise, load_ok, is_idle, trigger, fire;
  logic [COLS-1:0]             up_row, mid_row, dn_row, next_row;

  assign vs_rise = sync1_q & ~sync1_d_q;
  assign load_ok = load_valid & (int'(load_row) < ROWS);

  // A load or clear in the trigger cycle takes priority; the trigger waits for the next edge.
  always_comb begin
    is_idle = (state_q == IDLE);
    trigger = step_pending_q | (run & (frame_cnt_q == FRAME_LAST));
    fire    = is_idle & vs_rise & trigger & ~clear & ~load_ok;
  end

  always_comb begin
    up_row  = '0;
    dn_row  = '0;
    mid_row = grid_q[row_idx_q];
`ifdef LIFE_WRAP_EN
    up_row = (row_idx_q == '0)      ? grid_q[LAST_ROW] : grid_q[row_idx_q - 1'b1];
    dn_row = (row_idx_q == LAST_ROW) ? grid_q[0]        : grid_q[row_idx_q + 1'b1];
`else
    if (row_idx_q != '0)       up_row = grid_q[row_idx_q - 1'b1];
    if (row_idx_q != LAST_ROW) dn_row = grid_q[row_idx_q + 1'b1];
`endif
  end

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      localparam int LC = (gi == 0) ? COLS - 1 : gi - 1;
      localparam int RC = (gi == COLS - 1) ? 0 : gi + 1;
`ifdef LIFE_WRAP_EN
      localparam logic LV = 1'b1;
      localparam logic RV = 1'b1;
`else
      localparam logic LV = (gi != 0);
      localparam logic RV = (gi != COLS - 1);
`endif
      logic [3:0] n;
      assign n = 4'(up_row[LC] & LV) + 4'(up_row[gi]) + 4'(up_row[RC] & RV)
               + 4'(mid_row[LC] & LV) + 4'(mid_row[RC] & RV)
               + 4'(dn_row[LC] & LV) + 4'(dn_row[gi]) + 4'(dn_row[RC] & RV);
      assign next_row[gi] = (n == 4'd3) | (mid_row[gi] & (n == 4'd2));
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fire) state_d = COMPUTE;
      COMPUTE: if (row_idx_q == LAST_ROW) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q == IDLE);
    busy       = (state_q == COMPUTE) | (state_q == COMMIT);
  end

  always_comb begin
    grid_d         = grid_q;
    shadow_d       = shadow_q;
    gen_count_d    = gen_count_q;
    row_idx_d      = row_idx_q;
    frame_cnt_d    = frame_cnt_q;
    step_pending_d = step | (step_pending_q & ~fire);
    // Hold at the last count so a deferred run trigger still fires on the next edge.
    if (!run || fire)
      frame_cnt_d = '0;
    else if (is_idle && vs_rise && (frame_cnt_q != FRAME_LAST))
      frame_cnt_d = frame_cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (clear) begin
          grid_d      = '0;
          gen_count_d = '0;
        end else if (load_ok) begin
          grid_d[load_row] = load_data;
        end
        if (fire) row_idx_d = '0;
      end
      COMPUTE: begin
        shadow_d[row_idx_q] = next_row;
        row_idx_d = (row_idx_q == LAST_ROW) ? '0 : row_idx_q + 1'b1;
      end
      COMMIT: begin
        grid_d      = shadow_q;
        gen_count_d = gen_count_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      grid_q         <= '0;
      shadow_q       <= '0;
      gen_count_q    <= '0;
      row_idx_q      <= '0;
      frame_cnt_q    <= '0;
      step_pending_q <= 1'b0;
      sync0_q        <= 1'b0;
      sync1_q        <= 1'b0;
      sync1_d_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      grid_q         <= grid_d;
      shadow_q       <= shadow_d;
      gen_count_q    <= gen_count_d;
      row_idx_q      <= row_idx_d;
      frame_cnt_q    <= frame_cnt_d;
      step_pending_q <= step_pending_d;
      sync0_q        <= vsync;
      sync1_q        <= sync0_q;
      sync1_d_q      <= sync1_q;
    end
  end

  assign grid      = grid_q;
  assign gen_count = gen_count_q;

endmodule
